// File: rtl/rnd_hex_gen_if.sv
// Connection between the random hex source and the 4-digit hex display.
// Carries the raw push-button in and the display value/status out.
interface rnd_hex_gen_if;
   logic        i_btn;
   logic [15:0] o_data;
   logic        o_valid;
   logic        o_rolling;
   logic [7:0]  o_roll_cnt;

   modport master (
      input  i_btn,
      output o_data,
      output o_valid,
      output o_rolling,
      output o_roll_cnt
   );

   modport slave (
      output i_btn,
      input  o_data,
      input  o_valid,
      input  o_rolling,
      input  o_roll_cnt
   );
endinterface

// File: rtl/rnd_hex_gen.sv
// Button-driven random value source: while the button is held the value rolls,
// and on release the final LFSR value is frozen and announced with a strobe.
module rnd_hex_gen #(
   parameter int          DB_WIDTH = 16,
   parameter int          ROLL_DIV = 4096,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input logic          clk,
   input logic          rst,
   rnd_hex_gen_if.master bus
);

   // A zero seed would lock the LFSR at zero forever, so it is replaced.
   localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam int          DIV_W     = (ROLL_DIV > 1) ? $clog2(ROLL_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ROLL_DIV - 1);

   typedef enum logic {
      IDLE = 1'b0,
      ROLL = 1'b1
   } state_t;

   logic                btn_meta;
   logic                btn_s;
   logic                db;
   logic                db_prev;
   logic [DB_WIDTH-1:0] db_cnt;
   logic [15:0]         lfsr;
   logic [DIV_W-1:0]    div_cnt;
   state_t              state;
   logic [15:0]         data_q;
   logic                valid_q;
   logic                rolling_q;
   logic [7:0]          roll_cnt_q;

   logic rise;
   logic fall;
   logic div_done;

   assign rise     = db & ~db_prev;
   assign fall     = ~db & db_prev;
   assign div_done = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
         db       <= 1'b0;
         db_prev  <= 1'b0;
         db_cnt   <= '0;
      end else begin
         btn_meta <= bus.i_btn;
         btn_s    <= btn_meta;
         db_prev  <= db;
         // Any return to the settled level restarts the qualification window.
         if (btn_s == db) begin
            db_cnt <= '0;
         end else if (db_cnt == {DB_WIDTH{1'b1}}) begin
            db     <= btn_s;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= LFSR_INIT;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         div_cnt    <= '0;
         data_q     <= 16'h0000;
         valid_q    <= 1'b0;
         rolling_q  <= 1'b0;
         roll_cnt_q <= 8'h00;
      end else begin
         valid_q <= 1'b0;
         case (state)
            IDLE: begin
               rolling_q <= 1'b0;
               if (rise) begin
                  state     <= ROLL;
                  div_cnt   <= '0;
                  data_q    <= lfsr;
                  rolling_q <= 1'b1;
               end
            end
            ROLL: begin
               rolling_q <= 1'b1;
               // Release wins over a coincident roll tick so the value loads once.
               if (fall) begin
                  state     <= IDLE;
                  data_q    <= lfsr;
                  valid_q   <= 1'b1;
                  rolling_q <= 1'b0;
                  if (roll_cnt_q != 8'hFF) begin
                     roll_cnt_q <= roll_cnt_q + 8'd1;
                  end
               end else if (div_done) begin
                  data_q  <= lfsr;
                  div_cnt <= '0;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               rolling_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_data     = data_q;
   assign bus.o_valid    = valid_q;
   assign bus.o_rolling  = rolling_q;
   assign bus.o_roll_cnt = roll_cnt_q;

endmodule

// File: tb/tb_rnd_hex_gen.sv
// Directed bench for rnd_hex_gen with a short debounce window and fast roll rate.
module tb_rnd_hex_gen;

   logic clk;
   logic rst;
   int   n_compared;
   int   n_mismatched;
   int   cyc;

   rnd_hex_gen_if bus ();

   rnd_hex_gen #(
      .DB_WIDTH (3),
      .ROLL_DIV (4),
      .SEED     (16'hACE1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         at_cycle;
      logic       btn;
      logic       exp_rolling;
      logic       exp_valid;
      int         data_steps;
      logic [7:0] exp_cnt;
   } vec_t;

   // Expected display value: the seed advanced n times (negative means the reset value).
   function automatic logic [15:0] lfsr_adv(input int n);
      logic [15:0] v;
      v = 16'hACE1;
      for (int k = 0; k < n; k++) begin
         v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
      end
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s @cyc %0d: got %h, expected %h", name, cyc, actual, expected);
      end
   endtask

   task automatic apply_stimulus();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      bus.i_btn = 1'b0;
      repeat (3) apply_stimulus();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic wait_rolling(input logic level, input int max_cycles, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < max_cycles; k++) begin
         apply_stimulus();
         if (bus.o_rolling === level) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_valid(input int max_cycles, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < max_cycles; k++) begin
         apply_stimulus();
         if (bus.o_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t       vecs [$];
      bit         ok;
      bit         seen_roll;
      bit         seen_valid;
      int         n_valid;
      int         n_wide;
      logic [7:0] exp_sat;

      n_compared   = 0;
      n_mismatched = 0;
      cyc          = 0;
      rst          = 1'b1;
      bus.i_btn    = 1'b0;

      // Press at cycle 1, release at 26; second press at 45 released at 57 so the fall hits a roll tick at 68.
      vecs.push_back('{ 1, 1'b1, 1'b0, 1'b0, -1, 8'h00});
      vecs.push_back('{11, 1'b1, 1'b0, 1'b0, -1, 8'h00});
      vecs.push_back('{12, 1'b1, 1'b1, 1'b0, 11, 8'h00});
      vecs.push_back('{15, 1'b1, 1'b1, 1'b0, 11, 8'h00});
      vecs.push_back('{16, 1'b1, 1'b1, 1'b0, 15, 8'h00});
      vecs.push_back('{19, 1'b1, 1'b1, 1'b0, 15, 8'h00});
      vecs.push_back('{20, 1'b1, 1'b1, 1'b0, 19, 8'h00});
      vecs.push_back('{24, 1'b1, 1'b1, 1'b0, 23, 8'h00});
      vecs.push_back('{26, 1'b0, 1'b1, 1'b0, 23, 8'h00});
      vecs.push_back('{36, 1'b0, 1'b1, 1'b0, 35, 8'h00});
      vecs.push_back('{37, 1'b0, 1'b0, 1'b1, 36, 8'h01});
      vecs.push_back('{38, 1'b0, 1'b0, 1'b0, 36, 8'h01});
      vecs.push_back('{45, 1'b1, 1'b0, 1'b0, 36, 8'h01});
      vecs.push_back('{55, 1'b1, 1'b0, 1'b0, 36, 8'h01});
      vecs.push_back('{56, 1'b1, 1'b1, 1'b0, 55, 8'h01});
      vecs.push_back('{57, 1'b0, 1'b1, 1'b0, 55, 8'h01});
      vecs.push_back('{60, 1'b0, 1'b1, 1'b0, 59, 8'h01});
      vecs.push_back('{67, 1'b0, 1'b1, 1'b0, 63, 8'h01});
      vecs.push_back('{68, 1'b0, 1'b0, 1'b1, 67, 8'h02});
      vecs.push_back('{69, 1'b0, 1'b0, 1'b0, 67, 8'h02});
      vecs.push_back('{72, 1'b0, 1'b0, 1'b0, 67, 8'h02});

      $display("[TB] reset state");
      do_reset();
      check_output("reset_data", 32'(bus.o_data), 32'h0000);
      check_output("reset_valid", 32'(bus.o_valid), 32'h0);
      check_output("reset_rolling", 32'(bus.o_rolling), 32'h0);
      check_output("reset_cnt", 32'(bus.o_roll_cnt), 32'h00);
      apply_stimulus();
      check_output("lfsr_first", 32'(dut.lfsr), 32'h59C3);

      $display("[TB] press/hold/release and fall on roll tick");
      foreach (vecs[i]) begin
         while (cyc < vecs[i].at_cycle) apply_stimulus();
         check_output($sformatf("vec%0d_rolling", i), 32'(bus.o_rolling), 32'(vecs[i].exp_rolling));
         check_output($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'(vecs[i].exp_valid));
         check_output($sformatf("vec%0d_data", i), 32'(bus.o_data),
                      (vecs[i].data_steps < 0) ? 32'h0 : 32'(lfsr_adv(vecs[i].data_steps)));
         check_output($sformatf("vec%0d_cnt", i), 32'(bus.o_roll_cnt), 32'(vecs[i].exp_cnt));
         bus.i_btn = vecs[i].btn;
      end

      $display("[TB] bounce rejection");
      do_reset();
      seen_roll  = 1'b0;
      seen_valid = 1'b0;
      for (int c = 0; c < 60; c++) begin
         bus.i_btn = (c < 40) ? (((c / 3) % 2) == 0) : 1'b0;
         apply_stimulus();
         if (bus.o_rolling !== 1'b0) seen_roll = 1'b1;
         if (bus.o_valid !== 1'b0) seen_valid = 1'b1;
      end
      check_output("bounce_rolling", 32'(seen_roll), 32'h0);
      check_output("bounce_valid", 32'(seen_valid), 32'h0);
      check_output("bounce_data", 32'(bus.o_data), 32'h0000);

      $display("[TB] roll count saturation");
      n_valid = 0;
      n_wide  = 0;
      for (int k = 0; k < 260; k++) begin
         bus.i_btn = 1'b1;
         wait_rolling(1'b1, 40, ok);
         if (!ok) check_output("sat_press_timeout", 32'h0, 32'h1);
         repeat (2) apply_stimulus();
         bus.i_btn = 1'b0;
         wait_valid(40, ok);
         if (!ok) begin
            check_output("sat_release_timeout", 32'h0, 32'h1);
         end else begin
            n_valid++;
            exp_sat = (k + 1 > 255) ? 8'hFF : 8'(k + 1);
            check_output($sformatf("sat%0d_cnt", k), 32'(bus.o_roll_cnt), 32'(exp_sat));
            apply_stimulus();
            if (bus.o_valid !== 1'b0) n_wide++;
         end
      end
      check_output("sat_valid_pulses", 32'(n_valid), 32'd260);
      check_output("sat_valid_width", 32'(n_wide), 32'd0);
      check_output("sat_final_cnt", 32'(bus.o_roll_cnt), 32'hFF);

      $display("[TB] reset mid-roll");
      bus.i_btn = 1'b1;
      wait_rolling(1'b1, 40, ok);
      check_output("midroll_rolling", 32'(ok), 32'h1);
      repeat (3) apply_stimulus();
      rst       = 1'b1;
      bus.i_btn = 1'b0;
      apply_stimulus();
      check_output("midroll_data", 32'(bus.o_data), 32'h0000);
      check_output("midroll_valid", 32'(bus.o_valid), 32'h0);
      check_output("midroll_rolling_rst", 32'(bus.o_rolling), 32'h0);
      check_output("midroll_cnt", 32'(bus.o_roll_cnt), 32'h00);
      rst = 1'b0;
      cyc = 0;
      apply_stimulus();
      check_output("midroll_lfsr_first", 32'(dut.lfsr), 32'h59C3);
      seen_roll  = 1'b0;
      seen_valid = 1'b0;
      for (int c = 0; c < 30; c++) begin
         apply_stimulus();
         if (bus.o_rolling !== 1'b0) seen_roll = 1'b1;
         if (bus.o_valid !== 1'b0) seen_valid = 1'b1;
      end
      check_output("midroll_after_rolling", 32'(seen_roll), 32'h0);
      check_output("midroll_after_valid", 32'(seen_valid), 32'h0);
      check_output("midroll_after_cnt", 32'(bus.o_roll_cnt), 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/rnd_hex_gen.md
Name: rnd_hex_gen

Overview:
- Random-value source that sits directly upstream of the 4-digit hex display and drives its 16-bit data input.
- Takes one raw, bouncy push-button, synchronises and debounces it, and runs a free-running 16-bit LFSR.
- While the button is held, the output value "rolls" at a visible rate. On release, the final value is frozen and announced with a one-cycle strobe.

Parameters:
- DB_WIDTH, 16: debounce counter width; the synchronised button must disagree with the debounced level for 2^DB_WIDTH consecutive cycles before the debounced level changes.
- ROLL_DIV, 4096: clock cycles between o_data updates while rolling; legal range ≥ 1.
- SEED, 16'hACE1: LFSR reset value. SEED == 0 is illegal; if SEED == 0, the LFSR loads 16'h0001 instead.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_btn  in  1  raw button, asynchronous to clk, bouncy.
- o_data  out  16  value for the hex display; stable except on update cycles.
- o_valid  out  1  one-cycle pulse: final value latched on release.
- o_rolling  out  1  high while in ROLL state.
- o_roll_cnt  out  8  number of completed rolls, saturating.

Behaviour:
- Reset (sampled on a rising clk edge with rst = 1):
  - o_data = 16'h0000; o_valid = 0; o_rolling = 0; o_roll_cnt = 8'h00.
  - Sync flops = 0; debounced level = 0; debounce counter = 0; divider = 0.
  - LFSR = SEED (or 16'h0001 if SEED == 0); state = IDLE.
  - rst has priority over all other activity, including mid-roll: no o_valid is produced and no count is incremented.
- Synchroniser: two flops on i_btn producing btn_s. Latency is 2 cycles.
- Debounce:
  - When btn_s == db, the counter clears.
  - When btn_s != db and the counter < 2^DB_WIDTH−1, the counter increments.
  - When btn_s != db and the counter == 2^DB_WIDTH−1, db <= btn_s and the counter clears.
  - Net latency from a clean i_btn edge to a db edge is 2 + 2^DB_WIDTH cycles. Any glitch back to the old level restarts the count.
  - Edge detect on db gives a rise pulse and a fall pulse, each one cycle, registered against the previous db.
- LFSR:
  - Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Advances every non-reset cycle, independent of state.
  - Update: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Period is 65535 and never reaches 0. With SEED = ACE1, the first post-reset value is 16'h59C3.
- State machine, two states:
  - IDLE:
    - o_rolling = 0 and o_data holds.
    - On a rise pulse: go to ROLL, divider <= 0, and o_data <= lfsr in the same edge, so the display changes immediately.
  - ROLL:
    - o_rolling = 1 and the divider counts 0..ROLL_DIV−1.
    - At terminal count: o_data <= lfsr and divider <= 0.
    - On a fall pulse:
      - o_data <= lfsr and state <= IDLE.
      - o_valid = 1 on the following cycle, for exactly one cycle.
      - o_roll_cnt increments, holding at 8'hFF once reached.
    - If the fall pulse coincides with the divider terminal count, the fall takes priority; o_data is loaded once with the current lfsr.
  - A rise pulse while in ROLL is impossible by construction; the implementation ignores it.
- Outputs are all registered; no combinational path from i_btn to any output.
- o_data is captured from the LFSR value present before that edge's LFSR update.

Test Plan:
- Reset: assert rst for 3 cycles, then release → o_data = 0000, o_valid = 0, o_rolling = 0, o_roll_cnt = 00; LFSR model value 59C3 after the first free clock.
- Clean press, hold and release (DB_WIDTH = 3, ROLL_DIV = 4):
  - o_rolling rises 2 + 8 + 1 cycles after the i_btn rise.
  - o_data changes every 4 cycles, each time matching the model LFSR.
  - After release, o_valid pulses once and o_data freezes at the model value; o_roll_cnt = 01.
- Bounce rejection (DB_WIDTH = 3): toggle i_btn every 3 cycles for 40 cycles, then hold it low → o_rolling never asserts, o_valid never pulses, o_data stays 0000.
- Fall on terminal count (ROLL_DIV = 4): time the release so the db fall coincides with divider = 3 → exactly one o_data load, one o_valid pulse, state returns to IDLE.
- Saturation: perform 260 press/release cycles → o_roll_cnt reaches FF and stays FF; o_valid still pulses on every release.
- Reset mid-roll: assert rst while o_rolling = 1 → on the next cycle all outputs are at reset values, no o_valid pulse, and o_roll_cnt = 00.
